// File: rtl/node_pkg.sv
// Shared definitions for the tree-node master: FSM encoding, fold opcodes
// and the sizing helper for the WAIT timer.
package node_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_COMBINE = 2'd3
  } state_t;

  localparam int OP_ADD = 0;
  localparam int OP_XOR = 1;

  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/node_child_tracker.sv
// Per-child handshake tracker: records the RD drop (ack), then the RD rise
// (done), and captures the child's result exactly once per run.
module node_child_tracker #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             enable,
  input  logic             crd,
  input  logic [WIDTH-1:0] cres,
  output logic             done,
  output logic             hit,
  output logic [WIDTH-1:0] val
);

  logic ack;

  // Completion this cycle; lets the master leave WAIT without a bubble.
  assign hit = enable & ack & crd & ~done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack  <= 1'b0;
      done <= 1'b0;
      val  <= '0;
    end else if (clear) begin
      ack  <= 1'b0;
      done <= 1'b0;
    end else if (enable) begin
      if (!crd) ack <= 1'b1;
      if (hit) begin
        done <= 1'b1;
        val  <= cres;
      end
    end
  end

endmodule

// File: rtl/node_tree_master.sv
// Tree-node initiator: on an ST rising edge it starts all children, waits for
// each ack/done pair, folds the captured results and reports them on RES/RD.
module node_tree_master
  import node_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NCHILD  = 3,
  parameter int OP      = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ST,
  output logic                    RD,
  output logic [WIDTH-1:0]        RES,
  output logic                    ERR,
  output logic [NCHILD-1:0]       CST,
  input  logic [NCHILD-1:0]       CRD,
  input  logic [NCHILD*WIDTH-1:0] CRES
);

  localparam int TW = timer_w(TIMEOUT);

  state_t state, state_n;
  logic                          st_old;
  logic                          start_edge;
  logic [TW-1:0]                 timer, timer_n;
  logic [NCHILD-1:0]             done, hit;
  logic [NCHILD-1:0][WIDTH-1:0]  cap;
  logic                          all_done, tmo, clear, enable;
  logic [WIDTH-1:0]              fold_v;
  logic                          rd_n, err_n;
  logic [WIDTH-1:0]              res_n;
  logic [NCHILD-1:0]             cst_n;

  assign start_edge = ST & ~st_old;
  assign clear      = (state == S_IDLE) & start_edge;
  assign enable     = (state == S_WAIT);
  assign all_done   = &(done | hit);
  assign tmo        = (timer == TW'(TIMEOUT - 1));

  for (genvar g = 0; g < NCHILD; g++) begin : g_trk
    node_child_tracker #(.WIDTH(WIDTH)) u_trk (
      .CLK    (CLK),
      .RST    (RST),
      .clear  (clear),
      .enable (enable),
      .crd    (CRD[g]),
      .cres   (CRES[g*WIDTH +: WIDTH]),
      .done   (done[g]),
      .hit    (hit[g]),
      .val    (cap[g])
    );
  end

  always_comb begin
    fold_v = '0;
    for (int i = 0; i < NCHILD; i++)
      fold_v = (OP == OP_XOR) ? (fold_v ^ cap[i]) : (fold_v + cap[i]);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start_edge) state_n = S_LAUNCH;
      S_LAUNCH:  state_n = S_WAIT;
      S_WAIT:    if (all_done) state_n = S_COMBINE;
                 else if (tmo) state_n = S_IDLE;
      S_COMBINE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Completion takes priority over timeout when both land on the same cycle.
  always_comb begin
    rd_n    = RD;
    res_n   = RES;
    err_n   = ERR;
    cst_n   = CST;
    timer_n = timer;
    case (state)
      S_IDLE: if (start_edge) begin
        rd_n    = 1'b0;
        err_n   = 1'b0;
        cst_n   = '1;
        timer_n = '0;
      end
      S_WAIT: begin
        timer_n = timer + 1'b1;
        if (!all_done && tmo) begin
          err_n = 1'b1;
          res_n = '0;
          cst_n = '0;
          rd_n  = 1'b1;
        end
      end
      S_COMBINE: begin
        res_n = fold_v;
        cst_n = '0;
        rd_n  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RD     <= 1'b1;
      RES    <= '0;
      ERR    <= 1'b0;
      CST    <= '0;
      timer  <= '0;
      st_old <= 1'b0;
    end else begin
      RD     <= rd_n;
      RES    <= res_n;
      ERR    <= err_n;
      CST    <= cst_n;
      timer  <= timer_n;
      st_old <= ST;
    end
  end

endmodule

// File: doc/node_tree_master.md
Name: node_tree_master

Overview:
- Initiator side of the tree-node ST/RD/RES start-ready handshake.
- On a rising edge of its own ST, it launches NCHILD child nodes through per-child start lines and waits for each child's RD to drop (acknowledge) and rise again (done).
- It captures each child's RES, folds the captured results with a fixed operation, and presents the result on RES with RD high.
- It sits at internal tree positions: responder to its parent, initiator to its children.

Parameters:
- WIDTH, 16, data width of RES and of each child result.
- NCHILD, 3, number of child nodes (1..8).
- OP, 0, fold operation: 0 = wrapping add mod 2^WIDTH, 1 = bitwise XOR.
- TIMEOUT, 255, maximum cycles spent in WAIT before error (>= 8).

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- ST  input  1  start from parent; a 0->1 transition, sampled on CLK, starts a run.
- RD  output  1  ready to parent; 0 while a run is in progress.
- RES  output  WIDTH  folded result; valid while RD=1 after a run.
- ERR  output  1  1 if the last run ended by timeout.
- CST  output  NCHILD  start lines to children.
- CRD  input  NCHILD  ready lines from children.
- CRES  input  NCHILD*WIDTH  child results; child i at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (RST=0, asynchronous): RD=1, RES=0, ERR=0, CST=0, state IDLE, STold=0, all ack/done bits 0, timer 0.
- STold is registered every cycle from ST. A start edge is ST=1 && STold=0 at a clock edge.
- States: IDLE, LAUNCH, WAIT, COMBINE.
- IDLE, on a start edge:
  - RD<=0, ERR<=0, CST<=all ones.
  - Clear ack/done bits, timer<=0.
  - Go to LAUNCH.
- IDLE, otherwise: hold all outputs.
- LAUNCH: CRD is ignored for one cycle, because children register the start edge. Go to WAIT.
- WAIT, per child i:
  - CRD[i]=0 sampled -> ack[i]<=1.
  - ack[i]=1 && CRD[i]=1 && done[i]=0 -> done[i]<=1 and capture CRES slice i into buffer i.
  - CST stays all ones throughout WAIT.
  - Timer increments each WAIT cycle.
  - When all done bits would be 1 (including children completing this cycle): go to COMBINE.
  - Else if timer == TIMEOUT-1: ERR<=1, RES<=0, CST<=0, RD<=1, go to IDLE.
  - Completion and timeout in the same cycle: completion wins.
- COMBINE (one cycle):
  - RES <= fold of buffers 0..NCHILD-1 per OP; add truncates to WIDTH bits.
  - CST<=0, RD<=1, go to IDLE.
- Latency with leaf children, where a leaf drops RD on seeing the edge and raises it 2 cycles later:
  - Start edge sampled at edge t.
  - Child ack sampled at t+2, done at t+4.
  - RES/RD=1 visible after edge t+5.
- CST is low for at least one cycle between runs, so children always see a fresh edge.
- Start edges in LAUNCH, WAIT or COMBINE are ignored; STold still tracks ST. ST held high after a run does not retrigger.
- Children finish in any order; each slice is captured exactly once per run. Later CRES changes after done[i] are ignored.
- Reset asserted mid-run: immediate return to reset values; the run is abandoned and no partial RES is produced.
- RES and ERR hold their values until the next run's COMBINE or timeout. ERR clears at the next start edge.

Decomposition:
- Package node_pkg:
  - state encoding (IDLE, LAUNCH, WAIT, COMBINE);
  - OP constants OP_ADD=0, OP_XOR=1;
  - a timer-width function ($clog2(TIMEOUT+1)).
- Sub-module node_child_tracker, one instance per child:
  - inputs CLK, RST, clear, enable, CRD bit, CRES slice;
  - outputs done bit and captured value;
  - holds the ack/done flags and the capture register.
- Top module: FSM, timer, fold, and ST edge detection.

Test Plan:
- NCHILD=3, OP=0, three leaf models with 0x0001/0x0002/0x0003; pulse ST -> RD falls after the sampling edge, RD rises 5 cycles later, RES=0x0006, ERR=0, CST was high exactly 5 cycles.
- OP=0 wrap: children 0xFFFF/0x0002/0x0000 -> RES=0x0001. OP=1 with 0x00F0/0x0F0F/0x0001 -> RES=0x0FFE.
- Child 1 delays its RD rise by 20 cycles and changes CRES after done -> RES uses the value present at its done cycle, RD rises 20 cycles later than the baseline, children 0 and 2 are captured once.
- Child 2 never drops RD, TIMEOUT=16 -> after 16 WAIT cycles ERR=1, RES=0x0000, RD=1, CST=0. The next start edge clears ERR.
- Second ST pulse mid-WAIT, then ST held high through completion -> single run only, RES correct, no relaunch. A new ST 0->1 starts a fresh run.
- RST low during WAIT -> RD=1, RES=0, CST=0 immediately without a clock edge. After release, a normal run gives the correct result.
